// File: rtl/lsu_pkg.sv
// Shared types and sizes for the LSU memory stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_TAG_WIDTH = 6;
    localparam int LDQ_SIZE      = 4;
    localparam int STQ_SIZE      = 4;
    localparam int LDQ_IDX_W     = $clog2(LDQ_SIZE);
    localparam int STQ_IDX_W     = $clog2(STQ_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LD_MEM,
        LD_WAIT,
        ST_REQ,
        ST_WAIT
    } mem_stage_state_t;

    typedef struct packed {
        logic                     valid;
        logic                     address_valid;
        logic [XLEN-1:0]          address;
        logic                     executed;
        logic                     succeeded;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } load_queue_entry;

    typedef struct packed {
        logic                     valid;
        logic                     committed;
        logic                     address_valid;
        logic                     data_valid;
        logic [XLEN-1:0]          address;
        logic [XLEN-1:0]          data;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } store_queue_entry;

    // A load may be sent to the memory stage once its address is known and it
    // has not already been executed or completed.
    function automatic logic load_issuable(input load_queue_entry e);
        return e.valid & e.address_valid & ~e.executed & ~e.succeeded;
    endfunction

    // A store is written to the cache only when fully resolved and committed.
    function automatic logic store_eligible(input store_queue_entry e);
        return e.valid & e.committed & e.address_valid & e.data_valid;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_select.sv
// Wrap-around priority picker: first set bit at or after head, modulo DEPTH.
// Latency: combinational.
// Backpressure: none; DEPTH must be a power of two so the index wraps naturally.
module oldest_ready_select #(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready,
    input  logic [IDX_W-1:0] head,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] pos;

    // Scan oldest-first from head; the first ready slot wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head + IDX_W'(i);
            if (!found && ready[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage controller: issues the committed STQ head or the oldest ready load to L1.
// Latency: select c0, request c1, response c2, success pulse c3 (forwarded load: success c2).
// Backpressure: single outstanding request; mem_req_* held stable until mem_req_ready.
module lsu_mem_stage
    import lsu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  load_queue_entry          load_queue_entries [LDQ_SIZE],
    input  logic [LDQ_IDX_W-1:0]     ldq_head,
    input  store_queue_entry         store_queue_entries [STQ_SIZE],
    input  logic [STQ_IDX_W-1:0]     stq_head,
    output logic [LDQ_IDX_W-1:0]     ldq_mem_stage_index,
    input  logic                     kill_mem_req,
    input  logic                     forward,
    input  logic [STQ_IDX_W-1:0]     stq_forward_index,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [XLEN-1:0]          mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_data,
    output logic                     load_executed,
    output logic [LDQ_IDX_W-1:0]     load_executed_index,
    output logic                     load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
    output logic [XLEN-1:0]          load_result,
    output logic                     store_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag
);

    mem_stage_state_t         state;
    logic [LDQ_IDX_W-1:0]     ld_idx;
    logic [XLEN-1:0]          req_addr;
    logic [XLEN-1:0]          st_data;
    logic [ROB_TAG_WIDTH-1:0] op_tag;

    logic [LDQ_SIZE-1:0]      ld_ready;
    logic                     ld_found;
    logic [LDQ_IDX_W-1:0]     ld_pick;
    logic                     store_go;

    // Per-entry issuable flags for the picker.
    always_comb begin
        ld_ready = '0;
        for (int i = 0; i < LDQ_SIZE; i++) begin
            ld_ready[i] = load_issuable(load_queue_entries[i]);
        end
    end

    oldest_ready_select #(
        .DEPTH (LDQ_SIZE)
    ) u_ld_select (
        .ready (ld_ready),
        .head  (ldq_head),
        .found (ld_found),
        .index (ld_pick)
    );

    // The STQ only pops the head after seeing store_succeeded, so during that
    // pulse the just-written store still looks eligible and must not reissue.
    assign store_go = store_eligible(store_queue_entries[stq_head]) && !store_succeeded;

    assign mem_req_valid       = (state == ST_REQ) ||
                                 ((state == LD_MEM) && !kill_mem_req && !forward);
    assign mem_req_write       = (state == ST_REQ);
    assign mem_req_addr        = mem_req_valid ? req_addr : '0;
    assign mem_req_wdata       = mem_req_write ? st_data : '0;
    assign load_executed       = (state == LD_MEM) && !kill_mem_req &&
                                 (forward || mem_req_ready);
    assign load_executed_index = ld_idx;
    assign ldq_mem_stage_index = ld_idx;

    // Stage FSM with operand latches and registered success outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            ld_idx                  <= '0;
            req_addr                <= '0;
            st_data                 <= '0;
            op_tag                  <= '0;
            load_succeeded          <= 1'b0;
            load_succeeded_rob_tag  <= '0;
            load_result             <= '0;
            store_succeeded         <= 1'b0;
            store_succeeded_rob_tag <= '0;
        end else begin
            load_succeeded  <= 1'b0;
            store_succeeded <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_go) begin
                        req_addr <= store_queue_entries[stq_head].address;
                        st_data  <= store_queue_entries[stq_head].data;
                        op_tag   <= store_queue_entries[stq_head].rob_tag;
                        state    <= ST_REQ;
                    end else if (ld_found) begin
                        ld_idx   <= ld_pick;
                        req_addr <= load_queue_entries[ld_pick].address;
                        op_tag   <= load_queue_entries[ld_pick].rob_tag;
                        state    <= LD_MEM;
                    end
                end
                LD_MEM: begin
                    if (kill_mem_req) begin
                        // Load stays issuable in the LDQ and is picked again.
                        state <= IDLE;
                    end else if (forward) begin
                        load_result            <= store_queue_entries[stq_forward_index].data;
                        load_succeeded_rob_tag <= op_tag;
                        load_succeeded         <= 1'b1;
                        state                  <= IDLE;
                    end else if (mem_req_ready) begin
                        state <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (mem_resp_valid) begin
                        load_result            <= mem_resp_data;
                        load_succeeded_rob_tag <= op_tag;
                        load_succeeded         <= 1'b1;
                        state                  <= IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        store_succeeded_rob_tag <= op_tag;
                        store_succeeded         <= 1'b1;
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized queues/memory.
// Latency: checks exact cycle of request, executed and success pulses.
// Backpressure: randomized mem_req_ready, response delay, kill and forward.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    load_queue_entry          ldq [LDQ_SIZE];
    store_queue_entry         stq [STQ_SIZE];
    logic [LDQ_IDX_W-1:0]     ldq_head;
    logic [STQ_IDX_W-1:0]     stq_head;
    logic [LDQ_IDX_W-1:0]     ldq_mem_stage_index;
    logic                     kill_mem_req;
    logic                     forward;
    logic [STQ_IDX_W-1:0]     stq_forward_index;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_write;
    logic [XLEN-1:0]          mem_req_addr;
    logic [XLEN-1:0]          mem_req_wdata;
    logic                     mem_resp_valid;
    logic [XLEN-1:0]          mem_resp_data;
    logic                     load_executed;
    logic [LDQ_IDX_W-1:0]     load_executed_index;
    logic                     load_succeeded;
    logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag;
    logic [XLEN-1:0]          load_result;
    logic                     store_succeeded;
    logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag;

    lsu_mem_stage dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_queue_entries      (ldq),
        .ldq_head                (ldq_head),
        .store_queue_entries     (stq),
        .stq_head                (stq_head),
        .ldq_mem_stage_index     (ldq_mem_stage_index),
        .kill_mem_req            (kill_mem_req),
        .forward                 (forward),
        .stq_forward_index       (stq_forward_index),
        .mem_req_valid           (mem_req_valid),
        .mem_req_ready           (mem_req_ready),
        .mem_req_write           (mem_req_write),
        .mem_req_addr            (mem_req_addr),
        .mem_req_wdata           (mem_req_wdata),
        .mem_resp_valid          (mem_resp_valid),
        .mem_resp_data           (mem_resp_data),
        .load_executed           (load_executed),
        .load_executed_index     (load_executed_index),
        .load_succeeded          (load_succeeded),
        .load_succeeded_rob_tag  (load_succeeded_rob_tag),
        .load_result             (load_result),
        .store_succeeded         (store_succeeded),
        .store_succeeded_rob_tag (store_succeeded_rob_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic load_queue_entry mk_ld(input logic [XLEN-1:0] a, input logic [ROB_TAG_WIDTH-1:0] t);
        load_queue_entry e;
        e               = '0;
        e.valid         = 1'b1;
        e.address_valid = 1'b1;
        e.address       = a;
        e.rob_tag       = t;
        return e;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < LDQ_SIZE; i++) ldq[i] = '0;
        for (int i = 0; i < STQ_SIZE; i++) stq[i] = '0;
        ldq_head          = '0;
        stq_head          = '0;
        kill_mem_req      = 1'b0;
        forward           = 1'b0;
        stq_forward_index = '0;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        mem_resp_data     = '0;
    endtask

    // Random-phase state
    logic [XLEN-1:0]          mem_model [16];
    logic [LDQ_IDX_W-1:0]     exp_order [$];
    logic [LDQ_IDX_W-1:0]     cur_idx;
    logic [LDQ_IDX_W-1:0]     li;
    logic [STQ_IDX_W-1:0]     si;
    logic [XLEN-1:0]          exp_res, resp_dat;
    logic [ROB_TAG_WIDTH-1:0] exp_ld_tag, exp_st_tag;
    logic                     resp_pend, pend_write, hs, pop_st;
    logic                     exp_ls_now, exp_ss_now, exp_ls_next, exp_ss_next;
    int                       resp_wait, ld_left, st_left, n_st, cyc;

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_req_valid", mem_req_valid, 0);
        check_eq("rst_req_addr", mem_req_addr, 0);
        check_eq("rst_ld_exec", load_executed, 0);
        check_eq("rst_ld_succ", load_succeeded, 0);
        check_eq("rst_st_succ", store_succeeded, 0);
        check_eq("rst_stage_idx", ldq_mem_stage_index, 0);
        check_eq("rst_ld_result", load_result, 0);

        // Basic load through memory
        ldq[2] = mk_ld(32'h100, 6'd5);
        mem_req_ready = 1'b1;
        #1 check_eq("t1_c0_noreq", mem_req_valid, 0);
        step();
        #1;
        check_eq("t1_c1_req", mem_req_valid, 1);
        check_eq("t1_c1_addr", mem_req_addr, 32'h100);
        check_eq("t1_c1_write", mem_req_write, 0);
        check_eq("t1_c1_exec", load_executed, 1);
        check_eq("t1_c1_exec_idx", load_executed_index, 2);
        step();
        ldq[2].executed = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        #1 check_eq("t1_c2_noreq", mem_req_valid, 0);
        check_eq("t1_c2_nosucc", load_succeeded, 0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t1_c3_succ", load_succeeded, 1);
        check_eq("t1_c3_tag", load_succeeded_rob_tag, 5);
        check_eq("t1_c3_data", load_result, 32'hDEADBEEF);
        clear_inputs();
        step();
        #1 check_eq("t1_c4_pulse", load_succeeded, 0);

        // Store has priority over a ready load
        stq[0] = '{valid: 1'b1, committed: 1'b1, address_valid: 1'b1, data_valid: 1'b1,
                   address: 32'h40, data: 32'h12, rob_tag: 6'd3};
        ldq[0] = mk_ld(32'h80, 6'd7);
        mem_req_ready = 1'b1;
        step();
        #1;
        check_eq("t2_st_req", mem_req_valid, 1);
        check_eq("t2_st_write", mem_req_write, 1);
        check_eq("t2_st_addr", mem_req_addr, 32'h40);
        check_eq("t2_st_wdata", mem_req_wdata, 32'h12);
        check_eq("t2_no_ld_exec", load_executed, 0);
        step();
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t2_st_succ", store_succeeded, 1);
        check_eq("t2_st_tag", store_succeeded_rob_tag, 3);
        check_eq("t2_no_reissue_req", mem_req_valid, 0);
        step();
        stq[0] = '0;
        stq_head = 1;
        #1;
        check_eq("t2_ld_req", mem_req_valid, 1);
        check_eq("t2_ld_write", mem_req_write, 0);
        check_eq("t2_ld_addr", mem_req_addr, 32'h80);
        step();
        ldq[0].executed = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0BADF00D;
        step();
        mem_resp_valid = 1'b0;
        #1;
        check_eq("t2_ld_tag", load_succeeded_rob_tag, 7);
        check_eq("t2_ld_data", load_result, 32'h0BADF00D);
        clear_inputs();
        step();

        // Kill in LD_MEM, then reselect
        ldq[0] = mk_ld(32'h180, 6'd8);
        mem_req_ready = 1'b1;
        step();
        kill_mem_req = 1'b1;
        #1;
        check_eq("t3_kill_noreq", mem_req_valid, 0);
        check_eq("t3_kill_noexec", load_executed, 0);
        step();
        kill_mem_req = 1'b0;
        #1 check_eq("t3_idle_noreq", mem_req_valid, 0);
        step();
        #1;
        check_eq("t3_reselect_req", mem_req_valid, 1);
        check_eq("t3_reselect_idx", ldq_mem_stage_index, 0);
        check_eq("t3_reselect_exec", load_executed, 1);
        step();
        ldq[0].executed = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h00001234;
        step();
        mem_resp_valid = 1'b0;
        #1 check_eq("t3_data", load_result, 32'h00001234);
        clear_inputs();
        step();

        // Store-to-load forwarding
        stq[1].valid = 1'b1;
        stq[1].data  = 32'h0000CAFE;
        ldq[0] = mk_ld(32'h200, 6'd9);
        mem_req_ready = 1'b1;
        step();
        forward = 1'b1;
        stq_forward_index = 1;
        #1;
        check_eq("t4_fwd_noreq", mem_req_valid, 0);
        check_eq("t4_fwd_exec", load_executed, 1);
        step();
        forward = 1'b0;
        ldq[0].executed = 1'b1;
        #1;
        check_eq("t4_fwd_succ", load_succeeded, 1);
        check_eq("t4_fwd_data", load_result, 32'h0000CAFE);
        check_eq("t4_fwd_tag", load_succeeded_rob_tag, 9);
        clear_inputs();
        step();

        // Wrap-around selection
        ldq_head = 3;
        ldq[3] = mk_ld(32'h300, 6'd11);
        ldq[1] = mk_ld(32'h310, 6'd12);
        step();
        #1 check_eq("t5_pick_head", ldq_mem_stage_index, 3);
        forward = 1'b1;
        #1 check_eq("t5_exec_idx", load_executed_index, 3);
        step();
        forward = 1'b0;
        ldq[3].executed = 1'b1;
        step();
        #1;
        check_eq("t5_pick_wrap", ldq_mem_stage_index, 1);
        check_eq("t5_wrap_addr", mem_req_addr, 32'h310);
        kill_mem_req = 1'b1;
        ldq[1] = '0;
        step();
        clear_inputs();
        step();

        // Backpressure then reset mid-transaction
        ldq[2] = mk_ld(32'h400, 6'd13);
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t6_hold_valid", mem_req_valid, 1);
            check_eq("t6_hold_addr", mem_req_addr, 32'h400);
            check_eq("t6_hold_noexec", load_executed, 0);
            step();
        end
        reset = 1'b1;
        clear_inputs();
        #1;
        check_eq("t6_rst_req", mem_req_valid, 0);
        check_eq("t6_rst_idx", ldq_mem_stage_index, 0);
        check_eq("t6_rst_succ", load_succeeded, 0);
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55;
        step();
        mem_resp_valid = 1'b0;
        #1 check_eq("t6_late_resp_ignored", load_succeeded, 0);
        step();
        #1;
        check_eq("t6_late_resp_ignored2", load_succeeded, 0);
        check_eq("t6_idle_noreq", mem_req_valid, 0);

        // Randomized queues, memory latency, kill and forward
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        resp_pend   = 1'b0;
        pend_write  = 1'b0;
        resp_wait   = 0;
        resp_dat    = '0;
        exp_ls_now  = 1'b0;
        exp_ss_now  = 1'b0;
        exp_res     = '0;
        exp_ld_tag  = '0;
        exp_st_tag  = '0;
        cur_idx     = '0;
        for (int b = 0; b < 40; b++) begin
            clear_inputs();
            ldq_head = LDQ_IDX_W'($urandom);
            stq_head = STQ_IDX_W'($urandom);
            exp_order.delete();
            for (int k = 0; k < LDQ_SIZE; k++) begin
                li = ldq_head + LDQ_IDX_W'(k);
                if ($urandom_range(0, 2) != 0) begin
                    ldq[li] = mk_ld(XLEN'($urandom_range(0, 15) * 4), ROB_TAG_WIDTH'($urandom));
                    exp_order.push_back(li);
                end
            end
            n_st = $urandom_range(0, STQ_SIZE - 1);
            for (int k = 0; k < STQ_SIZE; k++) begin
                si = stq_head + STQ_IDX_W'(k);
                stq[si].data = $urandom;
                if (k < n_st) begin
                    stq[si].valid         = 1'b1;
                    stq[si].committed     = 1'b1;
                    stq[si].address_valid = 1'b1;
                    stq[si].data_valid    = $urandom_range(0, 1) != 0;
                    stq[si].address       = XLEN'($urandom_range(0, 15) * 4);
                    stq[si].rob_tag       = ROB_TAG_WIDTH'($urandom);
                end
            end
            ld_left = exp_order.size();
            st_left = n_st;
            cyc = 0;
            while ((ld_left > 0 || st_left > 0) && cyc < 600) begin
                cyc++;
                mem_req_ready     = $urandom_range(0, 2) != 0;
                kill_mem_req      = $urandom_range(0, 5) == 0;
                forward           = $urandom_range(0, 4) == 0;
                stq_forward_index = STQ_IDX_W'($urandom);
                if (resp_pend && resp_wait == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = resp_dat;
                end else if (!resp_pend && $urandom_range(0, 7) == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = $urandom;
                end else begin
                    mem_resp_valid = 1'b0;
                end
                for (int k = 0; k < STQ_SIZE; k++)
                    if (stq[k].valid && !stq[k].data_valid && $urandom_range(0, 3) == 0)
                        stq[k].data_valid = 1'b1;
                #1;
                check_eq("rnd_ld_succ_timing", load_succeeded, exp_ls_now);
                check_eq("rnd_st_succ_timing", store_succeeded, exp_ss_now);
                if (load_succeeded) begin
                    check_eq("rnd_ld_tag", load_succeeded_rob_tag, exp_ld_tag);
                    check_eq("rnd_ld_data", load_result, exp_res);
                    ld_left--;
                end
                pop_st = 1'b0;
                if (store_succeeded) begin
                    check_eq("rnd_st_tag", store_succeeded_rob_tag, exp_st_tag);
                    st_left--;
                    pop_st = 1'b1;
                end
                exp_ls_next = 1'b0;
                exp_ss_next = 1'b0;
                if (load_executed) begin
                    if (exp_order.size() == 0) begin
                        check_eq("rnd_unexpected_exec", 1, 0);
                    end else begin
                        check_eq("rnd_exec_order", load_executed_index, exp_order[0]);
                        void'(exp_order.pop_front());
                    end
                    cur_idx = load_executed_index;
                    exp_ld_tag = ldq[cur_idx].rob_tag;
                    ldq[cur_idx].executed = 1'b1;
                    if (forward) begin
                        exp_res     = stq[stq_forward_index].data;
                        exp_ls_next = 1'b1;
                    end
                end
                hs = mem_req_valid && mem_req_ready;
                if (hs) begin
                    check_eq("rnd_one_outstanding", resp_pend, 0);
                    pend_write = mem_req_write;
                    if (mem_req_write) begin
                        check_eq("rnd_st_addr", mem_req_addr, stq[stq_head].address);
                        check_eq("rnd_st_wdata", mem_req_wdata, stq[stq_head].data);
                        exp_st_tag = stq[stq_head].rob_tag;
                        mem_model[mem_req_addr[5:2]] = mem_req_wdata;
                        resp_dat = $urandom;
                    end else begin
                        check_eq("rnd_ld_addr", mem_req_addr, ldq[cur_idx].address);
                        exp_res  = mem_model[mem_req_addr[5:2]];
                        resp_dat = exp_res;
                    end
                    resp_pend = 1'b1;
                    resp_wait = $urandom_range(0, 2);
                end else if (resp_pend && mem_resp_valid) begin
                    resp_pend   = 1'b0;
                    exp_ls_next = !pend_write;
                    exp_ss_next = pend_write;
                end else if (resp_pend) begin
                    resp_wait--;
                end
                if (load_succeeded) ldq[cur_idx].succeeded = 1'b1;
                step();
                exp_ls_now = exp_ls_next;
                exp_ss_now = exp_ss_next;
                if (pop_st) begin
                    stq[stq_head] = '0;
                    stq_head = stq_head + 1'b1;
                end
            end
            check_eq("rnd_batch_loads_done", ld_left, 0);
            check_eq("rnd_batch_stores_done", st_left, 0);
            if (ld_left != 0 || st_left != 0) break;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
